// File: rtl/bus_target_mem.sv
// bus_target_mem: bus target with a local word memory, fixed-latency in-order responses and credit-limited requests.
// Optional build macro BUS_TARGET_STATS_EN adds saturating stat_rd / stat_wr / stat_err counters.
module bus_target_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 2,
    parameter int DEPTH       = 128,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ID_W-1:0]   req_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ID_W-1:0]   rsp_id,
    output logic              rsp_err,
    output logic              rsp_write
`ifdef BUS_TARGET_STATS_EN
    ,
    output logic [15:0]       stat_rd,
    output logic [15:0]       stat_wr,
    output logic [15:0]       stat_err
`endif
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(OUTSTANDING + 1);
    localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int ENT_W  = ID_W + 2 + DATA_W;
    localparam int PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0]  fifo_q [OUTSTANDING];

    logic              accept_s, in_range_s, push_s, pop_s, pipe_vld_s;
    logic [IDX_W-1:0]  idx_s;
    logic [DATA_W-1:0] rdata_s;
    logic [ENT_W-1:0]  acc_ent_s, pipe_ent_s;
    logic [CNT_W-1:0]  inflight_q, inflight_d, cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              req_ready_q, head_vld_q, head_vld_d;
    logic [ENT_W-1:0]  head_q, head_d;

    assign accept_s   = req_valid && req_ready_q;
    assign pop_s      = head_vld_q && rsp_ready;
    assign in_range_s = (32'(req_addr) < 32'(DEPTH));
    assign idx_s      = req_addr[IDX_W-1:0];
    assign acc_ent_s  = {req_id, req_write, ~in_range_s, rdata_s};

    // Read data is sampled at the accept edge; writes and errors return zero.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        if (!req_write && in_range_s) begin
            rdata_s = mem_q[idx_s];
        end else begin
            rdata_s = {DATA_W{1'b0}};
        end
    end

    // Memory array: intentionally not reset so accepted writes survive a reset.
    always_ff @(posedge clk) begin
        if (accept_s && req_write && in_range_s) begin
            mem_q[idx_s] <= req_wdata;
        end
    end

    // Credit counter: accepted-but-unretired requests.
    always_comb begin
        inflight_d = inflight_q;
        if (accept_s && !pop_s) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept_s && pop_s) begin
            inflight_d = inflight_q - CNT_W'(1);
        end else begin
            inflight_d = inflight_q;
        end
    end

    // Credit state and the registered ready derived from next-cycle credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q  <= CNT_W'(0);
            req_ready_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            req_ready_q <= (inflight_d < CNT_W'(OUTSTANDING));
        end
    end

    if (LATENCY == 1) begin : g_nopipe
        assign pipe_vld_s = accept_s;
        assign pipe_ent_s = acc_ent_s;
    end else begin : g_pipe
        logic [PIPE_N-1:0] vld_q;
        logic [ENT_W-1:0]  ent_q [PIPE_N];

        // Fixed-latency shift register; it never stalls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= {PIPE_N{1'b0}};
                for (int i = 0; i < PIPE_N; i++) begin
                    ent_q[i] <= {ENT_W{1'b0}};
                end
            end else begin
                vld_q[0] <= accept_s;
                ent_q[0] <= acc_ent_s;
                for (int i = 1; i < PIPE_N; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    ent_q[i] <= ent_q[i-1];
                end
            end
        end

        assign pipe_vld_s = vld_q[PIPE_N-1];
        assign pipe_ent_s = ent_q[PIPE_N-1];
    end

    assign push_s = pipe_vld_s;

    // Queue pointers, occupancy and the next head presented on rsp_*.
    always_comb begin
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        head_vld_d = 1'b0;
        head_d     = {ENT_W{1'b0}};
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // When the queue drains to just the incoming entry, that entry bypasses storage.
        if (cnt_d == CNT_W'(0)) begin
            head_vld_d = 1'b0;
            head_d     = {ENT_W{1'b0}};
        end else if ((cnt_q == CNT_W'(0)) || (pop_s && (cnt_q == CNT_W'(1)))) begin
            head_vld_d = 1'b1;
            head_d     = pipe_ent_s;
        end else begin
            head_vld_d = 1'b1;
            head_d     = fifo_q[rd_ptr_d];
        end
    end

    // Queue storage needs no reset; only pushed slots are ever read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= pipe_ent_s;
        end
    end

    // Queue control and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= CNT_W'(0);
            wr_ptr_q   <= PTR_W'(0);
            rd_ptr_q   <= PTR_W'(0);
            head_vld_q <= 1'b0;
            head_q     <= {ENT_W{1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = head_vld_q;
    assign rsp_rdata = head_q[DATA_W-1:0];
    assign rsp_err   = head_q[DATA_W];
    assign rsp_write = head_q[DATA_W+1];
    assign rsp_id    = head_q[ENT_W-1:DATA_W+2];

`ifdef BUS_TARGET_STATS_EN
    logic [15:0] stat_rd_q, stat_wr_q, stat_err_q;

    // Saturating counters of accepted reads, writes and out-of-range requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_q  <= 16'h0000;
            stat_wr_q  <= 16'h0000;
            stat_err_q <= 16'h0000;
        end else begin
            if (accept_s && !req_write && (stat_rd_q != 16'hFFFF)) begin
                stat_rd_q <= stat_rd_q + 16'h0001;
            end
            if (accept_s && req_write && (stat_wr_q != 16'hFFFF)) begin
                stat_wr_q <= stat_wr_q + 16'h0001;
            end
            if (accept_s && !in_range_s && (stat_err_q != 16'hFFFF)) begin
                stat_err_q <= stat_err_q + 16'h0001;
            end
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_err = stat_err_q;
`endif

endmodule
